// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the memory bus arbiter:
//     - arb_state_t : arbiter state / bus owner encoding
//     - W_BYTE/W_HALF/W_WORD : transfer width codes (log2 bytes)
//     - ABORT_DATA : read data returned to a master whose access timed out
//     - req_of() : a master is requesting when read or write is high
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_CPU = 2'd1,
      GRANT_DMA = 2'd2
   } arb_state_t;

   localparam logic [1:0]  W_BYTE     = 2'd0;
   localparam logic [1:0]  W_HALF     = 2'd1;
   localparam logic [1:0]  W_WORD     = 2'd2;

   localparam logic [31:0] ABORT_DATA = 32'hDEAD_DEAD;

   function automatic logic req_of(input logic read, input logic write);
      return read | write;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_prio.sv
// arb_prio_select
//   Combinational owner pick used while the arbiter is idle.
//   DMA has fixed priority, except that once DMA has used up its burst
//   allowance while the CPU was waiting, a requesting CPU wins.
// Ports:
//   cpu_req     in  CPU is requesting (read|write)
//   dma_req     in  DMA is requesting (read|write)
//   starve_hit  in  starvation counter has reached its limit
//   next_owner  out arb_state_t encoding of the winner (IDLE if none)
module arb_prio_select
   import mem_bus_arbiter_pkg::*;
(
   input  logic       cpu_req,
   input  logic       dma_req,
   input  logic       starve_hit,
   output logic [1:0] next_owner
);

   always_comb begin
      next_owner = IDLE;
      if (dma_req && !(starve_hit && cpu_req)) begin
         next_owner = GRANT_DMA;
      end else if (cpu_req) begin
         next_owner = GRANT_CPU;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory slave port between the CPU core and the DMA engine.
//   Fixed priority favours DMA; a starvation counter guarantees the CPU one
//   grant after MAX_DMA_BURST consecutive DMA completions it waited through.
//
//   Handshake: a master raises read or write (write wins if both) and holds
//   its request and address/data until its ok pulses for one cycle. A grant
//   starts the cycle after the request is seen in IDLE, lasts until mem_ok,
//   and is followed by one IDLE bubble. Dropping the request while granted
//   aborts the access without an ok.
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog ends a grant that has
//   waited TIMEOUT_CYCLES cycles without mem_ok; the owner gets ok with
//   ABORT_DATA and timeout_err pulses. Without the macro timeout_err is 0
//   and a grant is held indefinitely.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_* / dma_*             master requests, write data, read data, ok
//   mem_*                     slave port (addr/wdata/rdata/width/read/write/ok)
//   owner_dma                 DMA holds the bus
//   busy                      a transfer is granted
//   timeout_err               one-cycle watchdog abort pulse
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int MAX_DMA_BURST  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [1:0]  cpu_width,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ok,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [1:0]  dma_width,
   input  logic        dma_read,
   input  logic        dma_write,
   output logic [31:0] dma_rdata,
   output logic        dma_ok,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  mem_width,
   output logic        mem_read,
   output logic        mem_write,
   input  logic        mem_ok,
   output logic        owner_dma,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [7:0] BURST_LIM = 8'(MAX_DMA_BURST);

   arb_state_t state_q, state_d;
   logic [7:0] starve_cnt;
   logic [1:0] pick;
   logic       cpu_req, dma_req, starve_hit;
   logic       granted, owner_req, done, abort, tmo_hit;

   assign cpu_req    = req_of(cpu_read, cpu_write);
   assign dma_req    = req_of(dma_read, dma_write);
   assign starve_hit = (starve_cnt == BURST_LIM);

   assign granted    = (state_q != IDLE);
   assign owner_req  = ((state_q == GRANT_CPU) && cpu_req) ||
                       ((state_q == GRANT_DMA) && dma_req);
   // A completion needs the owner still requesting; mem_ok against a
   // dropped request is treated as part of the abort.
   assign done       = granted && owner_req && mem_ok;
   assign abort      = granted && !owner_req;

   assign owner_dma  = (state_q == GRANT_DMA);
   assign busy       = granted;

   arb_prio_select u_prio (
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
      .starve_hit (starve_hit),
      .next_owner (pick)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state_d == IDLE) begin
         tmo_cnt <= '0;
      end else if (granted && !mem_ok) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   // Only a still-requesting owner is timed out; a dropped request is an abort.
   assign tmo_hit     = granted && owner_req && !mem_ok && (tmo_cnt == TMO_LAST);
   assign timeout_err = tmo_hit;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   // State register: the state is the bus owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cpu_req || dma_req) begin
               state_d = arb_state_t'(pick);
            end
         end
         GRANT_CPU, GRANT_DMA: begin
            if (done || abort || tmo_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Starvation counter only moves on real completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (done) begin
         if (state_q == GRANT_CPU) begin
            starve_cnt <= '0;
         end else if (cpu_req) begin
            if (starve_cnt < BURST_LIM) begin
               starve_cnt <= starve_cnt + 8'd1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // Slave-side mux and master responses.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_width = W_WORD;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      cpu_rdata = '0;
      cpu_ok    = 1'b0;
      dma_rdata = '0;
      dma_ok    = 1'b0;
      case (state_q)
         GRANT_CPU: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_width = cpu_width;
            mem_write = cpu_write;
            mem_read  = cpu_read && !cpu_write;
            cpu_rdata = tmo_hit ? ABORT_DATA : mem_rdata;
            cpu_ok    = done || tmo_hit;
         end
         GRANT_DMA: begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_width = dma_width;
            mem_write = dma_write;
            mem_read  = dma_read && !dma_write;
            dma_rdata = tmo_hit ? ABORT_DATA : mem_rdata;
            dma_ok    = done || tmo_hit;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory slave port (addr/data/width/read/write/ok handshake) between the CPU core and the DMA engine. Fixed priority favours DMA, and an anti-starvation counter guarantees the CPU a slot. Sits between cpu_armv4t and the DMA block on one side and the memory/bus decoder on the other. CPU-side tristate data is split into rdata/wdata at the top level.

Parameters:
MAX_DMA_BURST, 4, consecutive DMA grants allowed while CPU is waiting before the CPU is forced one grant (1..255)
TIMEOUT_CYCLES, 1024, slave-ok watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  32  CPU address
cpu_wdata  in  32  CPU write data
cpu_width  in  2  log2 bytes (0 byte, 1 half, 2 word)
cpu_read  in  1  CPU read request, held until cpu_ok
cpu_write  in  1  CPU write request, held until cpu_ok
cpu_rdata  out  32  read data to CPU
cpu_ok  out  1  CPU transfer complete
dma_addr, dma_wdata, dma_width, dma_read, dma_write  in  32/32/2/1/1  same as CPU
dma_rdata  out  32  read data to DMA
dma_ok  out  1  DMA transfer complete
mem_addr  out  32  to slave
mem_wdata  out  32  to slave
mem_rdata  in  32  from slave
mem_width  out  2  to slave
mem_read  out  1  to slave
mem_write  out  1  to slave
mem_ok  in  1  slave completion
owner_dma  out  1  1 while DMA holds the bus
busy  out  1  1 while any transfer is granted
timeout_err  out  1  one-cycle abort pulse (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Request: a master requests when read|write is 1. read&write together is treated as write.
- States: IDLE, GRANT_CPU, GRANT_DMA. The state register is the owner.
- IDLE arbitration:
  - DMA wins if requesting, unless starve_cnt==MAX_DMA_BURST and the CPU is requesting. In that case the CPU wins.
  - Otherwise the CPU wins if requesting. With no request, stay in IDLE.
- Grant latency: a request seen in IDLE in cycle n drives the slave from cycle n+1. There is no same-cycle pass-through.
- In GRANT_x:
  - mem_* outputs are driven combinationally from master x; x_rdata = mem_rdata; x_ok = mem_ok.
  - The other master's ok is 0 and its rdata is 0.
- Completion: on mem_ok, return to IDLE the next cycle. There is always one idle bubble between grants.
- Abort: if the owner drops read|write before mem_ok (protocol violation), return to IDLE next cycle. No ok is issued and the counter is not updated.
- starve_cnt (8 bit), updated on completion only:
  - DMA completion while cpu request=1: increment, saturating at MAX_DMA_BURST.
  - CPU completion: clear.
  - DMA completion with CPU idle: clear.
- IDLE outputs: mem_read=mem_write=0, mem_addr=mem_wdata=0, mem_width=2, both ok=0, busy=0.
- owner_dma=(state==GRANT_DMA); busy=(state!=IDLE).
- Reset (including mid-transfer): state=IDLE, starve_cnt=0, timeout counter=0. All outputs take IDLE values the next cycle. An in-flight slave access is dropped, and the slave must tolerate deassertion.
- mem_ok while IDLE is ignored.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a 16-bit counter increments each granted cycle without mem_ok. When it reaches TIMEOUT_CYCLES-1, the arbiter forces IDLE next cycle, pulses timeout_err for one cycle and asserts owner ok with rdata=32'hDEADDEAD so the master unblocks. The counter clears on every transition into IDLE.
- Undefined: no counter; timeout_err=0; the grant is held indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=2'd0, GRANT_CPU=2'd1, GRANT_DMA=2'd2);
  - the width codes (W_BYTE=0, W_HALF=1, W_WORD=2);
  - the abort data constant 32'hDEADDEAD.
- One sub-module, arb_prio_select: a combinational priority pick from (cpu_req, dma_req, starve_cnt==MAX_DMA_BURST) yielding the next owner.
- Muxing and the FSM stay in the top module.

Test Plan:
- CPU-only read at 0x08000000, slave ok after 3 cycles -> mem_read from cycle n+1, cpu_ok with slave data 0x12345678 on ok cycle, IDLE next cycle, dma_ok never 1.
- CPU and DMA both request in the same IDLE cycle -> DMA granted first (owner_dma=1), CPU granted after DMA ok plus one bubble.
- DMA requests continuously and CPU waits, MAX_DMA_BURST=4 -> exactly 4 DMA completions, then one CPU grant, then DMA resumes; starve_cnt returns to 0.
- DMA byte write width=0, addr 0x03000001, wdata 0xAB -> mem_write=1, mem_width=0, mem_wdata=0xAB, dma_ok on mem_ok.
- rst asserted while GRANT_DMA and mem_ok pending -> next cycle mem_read=mem_write=0, busy=0, starve_cnt=0; a later request is granted normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> timeout_err pulse after 16 granted cycles, cpu_ok=1 with rdata 0xDEADDEAD, return to IDLE. Without the macro, the grant is still held at cycle 100.
